npc_mcore: RTL and testbench
============================

# npc_mcore

Parametrised multi-cycle RV32 integer core for the NPC, replacing the single-cycle fetch/decode/register-file/ALU top. It fetches through a valid/ready-style instruction-memory handshake, executes a small RV32I/E subset over a FETCH/EXEC state machine and drives retire and halt status for the simulation harness. It sits directly under the NPC simulation top. The harness ends simulation when `halt` asserts and reads `halt_code` and `a0`.

## Interface
- `XLEN`, default 32: datapath width; only 32 is supported, and any other value is an elaboration error.
- `NREG`, default 32: architectural register count, 32 (RV32I) or 16 (RV32E).
- `RESET_PC`, default 32'h8000_0000: PC value after reset.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request; held high in FETCH until accepted.
- `imem_addr`  out  XLEN  fetch address, equal to current PC.
- `imem_valid`  in  1  `imem_inst` valid; accepted only while `imem_req` is high.
- `imem_inst`  in  32  instruction word.
- `pc`  out  XLEN  current PC.
- `retire`  out  1  one-cycle pulse per completed instruction.
- `halt`  out  1  sticky; core stopped.
- `halt_code`  out  2  0 = ebreak, 1 = illegal instruction, 2 = misaligned jump target.
- `a0`  out  XLEN  live value of x10.

## Operation
- Supported instructions: ADDI, ADD, SUB, LUI, AUIPC, JAL, JALR, EBREAK. Every other encoding is illegal.
- Any rd/rs1/rs2 index ≥ NREG is also illegal.
- **FETCH** state:
  - `imem_req` is 1 and `imem_addr` equals `pc`.
  - On `imem_valid` = 1, capture `imem_inst` into IR and go to EXEC.
  - With `imem_valid` = 0, stay in FETCH with outputs stable.
- **EXEC** state: decode IR, read registers, compute the result, then do one of the following.
  - Normal: write rd, update pc (pc+4 or jump target), pulse `retire`, go to FETCH.
  - EBREAK: `halt` = 1, `halt_code` = 0, `retire` pulses, pc unchanged, go to HALT.
  - Illegal: `halt` = 1, `halt_code` = 1, no writeback, no retire, pc unchanged, go to HALT.
  - JAL/JALR target with bit 1 set: `halt_code` = 2, no writeback, no retire, pc unchanged, go to HALT.
  - JALR target: (rs1 + sext(imm)) with bit 0 cleared.
- **HALT** state: absorbing until reset. `imem_req` = 0, no writes, `retire` = 0.
- Arithmetic:
  - All operations are modulo 2^XLEN, with no overflow detection.
  - I-immediates are sign-extended from bit 31.
  - J-immediates are sign-extended 21-bit values with bit 0 = 0.
  - LUI/AUIPC use {inst[31:12], 12'b0}.
- x0:
  - Reads always return 0.
  - Writes to x0 are dropped, including JAL/JALR link writes.
- JAL/JALR with rd = rs1: rs1 is read before the link value is written.
- `imem_valid` outside FETCH is ignored.

## Timing
- Reset value of every output and of state:
  - state = FETCH, pc = `RESET_PC`, all registers = 0.
  - `imem_req` = 1 as soon as reset deasserts; it is 0 while `rst` is low.
  - `retire` = 0, `halt` = 0, `halt_code` = 0, `a0` = 0.
- Reset asserted mid-FETCH or mid-EXEC: the in-flight instruction is discarded with no writeback. `imem_req` drops combinationally with reset.
- Minimum 2 cycles per instruction.
  - Fetch accepted at edge N.
  - EXEC during cycle N to N+1, with `retire` high in that cycle.
  - Register and pc update at edge N+1.
  - The next `imem_req` uses the new pc from cycle N+1 onward.
- Each imem wait cycle adds one cycle.
- `halt` and `halt_code` become visible the cycle after the EXEC edge and remain stable.
- `a0` reflects register writes one cycle after the writing edge.

## Structure
- Package `npc_pkg` holds:
  - opcode/funct3/funct7 constants;
  - the state enum (FETCH, EXEC, HALT);
  - halt-code constants.
- Sub-module `npc_regfile` (params `XLEN`, `NREG`):
  - two combinational read ports and one write port;
  - asynchronous active-low clear;
  - x0 hardwired to 0;
  - exposes x10 as `a0`.
- Decode, ALU and FSM stay in `npc_mcore`.

## Test plan
- Reset, then memory returns 0x00500093 (addi x1,x0,5) with `imem_valid` in the first request cycle.
  - Required: `retire` in cycle 2, x1 = 5, pc = 0x8000_0004.
- Sequence 0x00500093, 0x12345137 (lui x2,0x12345), 0x002081B3 (add x3,x1,x2).
  - Required: x3 = 0x1234_5005, with 3 retires over 6 cycles at zero wait.
- Insert 3 wait cycles on `imem_valid`.
  - Required: `imem_req` and `imem_addr` stay stable, and retire is delayed by exactly 3 cycles.
- At pc 0x8000_0000, 0x008000EF (jal x1,+8).
  - Required: x1 = 0x8000_0004, pc = 0x8000_0008.
- Then jalr x0,2(x1) to a misaligned target.
  - Required: `halt` = 1, `halt_code` = 2, pc unchanged.
- Run 0x00700013 (addi x0,x0,7) then 0x00100073 (ebreak).
  - Required: x0 reads 0, `halt` = 1, `halt_code` = 0, `imem_req` = 0 thereafter.
- With NREG = 16, fetch addi x20,x0,1.
  - Required: `halt_code` = 1.
- Assert `rst` in the EXEC cycle of an addi.
  - Required: no writeback, pc = 0x8000_0000 after release.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared constants for the NPC multi-cycle core: RV32 opcodes, the FSM state
// enum and the halt-code encoding reported to the simulation harness.
package npc_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [6:0] F7_ADD = 7'h00;
  localparam logic [6:0] F7_SUB = 7'h20;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    HALT
  } state_t;

  localparam logic [1:0] HALT_EBREAK   = 2'd0;
  localparam logic [1:0] HALT_ILLEGAL  = 2'd1;
  localparam logic [1:0] HALT_MISALIGN = 2'd2;

endpackage

// File: rtl/npc_regfile.sv
// Architectural register file: two combinational reads, one write, x0 hardwired
// to zero, asynchronous active-low clear, x10 exposed for the harness.
module npc_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(NREG)-1:0] ra1,
  input  logic [$clog2(NREG)-1:0] ra2,
  output logic [XLEN-1:0]         rd1,
  output logic [XLEN-1:0]         rd2,
  input  logic                    we,
  input  logic [$clog2(NREG)-1:0] wa,
  input  logic [XLEN-1:0]         wd,
  output logic [XLEN-1:0]         a0
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  // Entry 0 is never written, but reads of x0 are forced to zero regardless.
  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
  assign a0  = regs[10];

endmodule

// File: rtl/npc_mcore.sv
// Multi-cycle RV32I/E subset core: FETCH/EXEC/HALT state machine with a
// valid/ready instruction fetch, decode and ALU kept local to this module.
module npc_mcore
  import npc_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               NREG     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_inst,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halt,
  output logic [1:0]      halt_code,
  output logic [XLEN-1:0] a0
);

  localparam int AW = $clog2(NREG);

  if (XLEN != 32) begin : g_bad_xlen
    $error("npc_mcore only supports XLEN = 32");
  end

  state_t          state, state_next;
  logic [XLEN-1:0] pc_q, pc_next;
  logic [31:0]     ir;
  logic [1:0]      code_q, code_next;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  logic [XLEN-1:0] imm_i, imm_u, imm_j, rs1_val, rs2_val;
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  logic            legal, is_ebreak, jump, use_rd, use_rs1, use_rs2;
  logic            illegal, misaligned, we;
  logic [XLEN-1:0] result, target;

  always_comb begin
    legal     = 1'b0;
    is_ebreak = 1'b0;
    jump      = 1'b0;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    result    = '0;
    target    = '0;
    case (opcode)
      OPC_OP_IMM: if (funct3 == F3_ADD) begin
        {legal, use_rd, use_rs1} = 3'b111;
        result = rs1_val + imm_i;
      end
      OPC_OP: if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB)) begin
        {legal, use_rd, use_rs1, use_rs2} = 4'b1111;
        result = (funct7 == F7_SUB) ? rs1_val - rs2_val : rs1_val + rs2_val;
      end
      OPC_LUI: begin
        {legal, use_rd} = 2'b11;
        result = imm_u;
      end
      OPC_AUIPC: begin
        {legal, use_rd} = 2'b11;
        result = pc_q + imm_u;
      end
      OPC_JAL: begin
        {legal, use_rd, jump} = 3'b111;
        result = pc_q + 32'd4;
        target = pc_q + imm_j;
      end
      OPC_JALR: if (funct3 == F3_ADD) begin
        {legal, use_rd, use_rs1, jump} = 4'b1111;
        result = pc_q + 32'd4;
        target = (rs1_val + imm_i) & ~32'd1;
      end
      OPC_SYSTEM: if (ir == INST_EBREAK) begin
        {legal, is_ebreak} = 2'b11;
      end
      default: ;
    endcase
  end

  // Register indices beyond NREG (RV32E) make an otherwise valid encoding illegal.
  assign illegal = !legal ||
                   (use_rd  && int'(rd)  >= NREG) ||
                   (use_rs1 && int'(rs1) >= NREG) ||
                   (use_rs2 && int'(rs2) >= NREG);
  assign misaligned = jump && target[1];

  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    code_next  = code_q;
    retire     = 1'b0;
    we         = 1'b0;
    case (state)
      FETCH: if (imem_valid) state_next = EXEC;
      EXEC: begin
        if (illegal) begin
          state_next = HALT;
          code_next  = HALT_ILLEGAL;
        end else if (is_ebreak) begin
          state_next = HALT;
          code_next  = HALT_EBREAK;
          retire     = 1'b1;
        end else if (misaligned) begin
          state_next = HALT;
          code_next  = HALT_MISALIGN;
        end else begin
          state_next = FETCH;
          retire     = 1'b1;
          we         = use_rd;
          pc_next    = jump ? target : pc_q + 32'd4;
        end
      end
      default: state_next = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= FETCH;
      pc_q   <= RESET_PC;
      ir     <= '0;
      code_q <= HALT_EBREAK;
    end else begin
      state  <= state_next;
      pc_q   <= pc_next;
      code_q <= code_next;
      if (state == FETCH && imem_valid) ir <= imem_inst;
    end
  end

  npc_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1[AW-1:0]),
    .ra2 (rs2[AW-1:0]),
    .rd1 (rs1_val),
    .rd2 (rs2_val),
    .we  (we),
    .wa  (rd[AW-1:0]),
    .wd  (result),
    .a0  (a0)
  );

  assign imem_req  = rst && (state == FETCH);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign halt      = (state == HALT);
  assign halt_code = code_q;

endmodule

// File: tb/tb_npc_mcore.sv
// Directed self-checking bench for npc_mcore: an RV32I instance for the main
// scenarios and an RV32E instance for the out-of-range register index case.
module tb_npc_mcore;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, imem_valid, imem_req, retire, halt;
  logic [31:0] imem_inst, imem_addr, pc, a0;
  logic [1:0]  halt_code;

  logic        rst_e, valid_e, req_e, retire_e, halt_e;
  logic [31:0] inst_e, addr_e, pc_e, a0_e;
  logic [1:0]  code_e;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  npc_mcore #(.XLEN(32), .NREG(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_inst(imem_inst), .pc(pc), .retire(retire),
    .halt(halt), .halt_code(halt_code), .a0(a0)
  );

  npc_mcore #(.XLEN(32), .NREG(16), .RESET_PC(RST_PC)) dut_e (
    .clk(clk), .rst(rst_e), .imem_req(req_e), .imem_addr(addr_e),
    .imem_valid(valid_e), .imem_inst(inst_e), .pc(pc_e), .retire(retire_e),
    .halt(halt_e), .halt_code(code_e), .a0(a0_e)
  );

  task automatic do_reset();
    rst = 1'b0;
    imem_valid = 1'b0;
    imem_inst = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Present one instruction in FETCH; returns retire sampled in the EXEC cycle.
  task automatic issue(input logic [31:0] inst, output logic ret);
    imem_inst = inst;
    imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    ret = retire;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    imem_valid = 1'b0;
    imem_inst = 32'h0050_0093;
    repeat (2) @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_req: got %0b want 0", imem_req); end
    n_cmp++; if (pc !== RST_PC) begin n_bad++; $display("[TB] FAIL reset_pc: got %h want %h", pc, RST_PC); end
    n_cmp++; if ({retire, halt, halt_code} !== 4'b0) begin n_bad++; $display("[TB] FAIL reset_status: got %b want 0000", {retire, halt, halt_code}); end
    n_cmp++; if (a0 !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_a0: got %h want 0", a0); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({imem_req, imem_addr} !== {1'b1, RST_PC}) begin n_bad++; $display("[TB] FAIL reset_release_req: got %b/%h want 1/%h", imem_req, imem_addr, RST_PC); end
  endtask

  task automatic test_addi();
    logic r;
    do_reset();
    #1;
    n_cmp++; if (retire !== 1'b0) begin n_bad++; $display("[TB] FAIL addi_fetch_retire: got %0b want 0", retire); end
    issue(32'h0050_0093, r);
    n_cmp++; if (r !== 1'b1) begin n_bad++; $display("[TB] FAIL addi_retire: got %0b want 1", r); end
    n_cmp++; if (pc !== 32'h8000_0004) begin n_bad++; $display("[TB] FAIL addi_pc: got %h want 80000004", pc); end
    issue(32'h0000_8533, r);
    n_cmp++; if (a0 !== 32'd5) begin n_bad++; $display("[TB] FAIL addi_x1: got %h want 5", a0); end
  endtask

  task automatic test_sequence();
    logic r;
    int cnt;
    cnt = 0;
    do_reset();
    issue(32'h0050_0093, r); cnt += int'(r);
    issue(32'h1234_5137, r); cnt += int'(r);
    issue(32'h0020_81B3, r); cnt += int'(r);
    n_cmp++; if (cnt != 3) begin n_bad++; $display("[TB] FAIL seq_retires: got %0d want 3", cnt); end
    n_cmp++; if (pc !== 32'h8000_000C) begin n_bad++; $display("[TB] FAIL seq_pc: got %h want 8000000c", pc); end
    issue(32'h0001_8533, r);
    n_cmp++; if (a0 !== 32'h1234_5005) begin n_bad++; $display("[TB] FAIL seq_x3: got %h want 12345005", a0); end
  endtask

  task automatic test_wait();
    do_reset();
    imem_inst = 32'h0050_0093;
    imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({imem_req, imem_addr, retire} !== {1'b1, RST_PC, 1'b0}) begin
        n_bad++;
        $display("[TB] FAIL wait_stable[%0d]: got req=%0b addr=%h ret=%0b want 1/%h/0", i, imem_req, imem_addr, retire, RST_PC);
      end
    end
    imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    n_cmp++; if (retire !== 1'b1) begin n_bad++; $display("[TB] FAIL wait_retire: got %0b want 1", retire); end
    @(negedge clk);
    n_cmp++; if (pc !== 32'h8000_0004) begin n_bad++; $display("[TB] FAIL wait_pc: got %h want 80000004", pc); end
  endtask

  task automatic test_jal();
    logic r;
    do_reset();
    issue(32'h0080_00EF, r);
    n_cmp++; if (r !== 1'b1) begin n_bad++; $display("[TB] FAIL jal_retire: got %0b want 1", r); end
    n_cmp++; if (pc !== 32'h8000_0008) begin n_bad++; $display("[TB] FAIL jal_pc: got %h want 80000008", pc); end
    issue(32'h0000_8533, r);
    n_cmp++; if (a0 !== 32'h8000_0004) begin n_bad++; $display("[TB] FAIL jal_link: got %h want 80000004", a0); end
    issue(32'h0020_8067, r);
    n_cmp++; if (r !== 1'b0) begin n_bad++; $display("[TB] FAIL jalr_mis_retire: got %0b want 0", r); end
    n_cmp++; if ({halt, halt_code} !== 3'b110) begin n_bad++; $display("[TB] FAIL jalr_mis_halt: got %0b/%0d want 1/2", halt, halt_code); end
    n_cmp++; if ({imem_req, pc} !== {1'b0, 32'h8000_000C}) begin n_bad++; $display("[TB] FAIL jalr_mis_pc: got req=%0b pc=%h want 0/8000000c", imem_req, pc); end
  endtask

  task automatic test_alu();
    logic r;
    do_reset();
    issue(32'hFFD0_0093, r);
    issue(32'h0050_0113, r);
    issue(32'h4020_8533, r);
    n_cmp++; if (a0 !== 32'hFFFF_FFF8) begin n_bad++; $display("[TB] FAIL alu_sub: got %h want fffffff8", a0); end
    issue(32'h0000_1517, r);
    n_cmp++; if (a0 !== 32'h8000_100C) begin n_bad++; $display("[TB] FAIL alu_auipc: got %h want 8000100c", a0); end
  endtask

  task automatic test_ebreak();
    logic r;
    do_reset();
    issue(32'h0070_0013, r);
    issue(32'h0010_0513, r);
    n_cmp++; if (a0 !== 32'd1) begin n_bad++; $display("[TB] FAIL x0_write_dropped: got %h want 1", a0); end
    issue(32'h0010_0073, r);
    n_cmp++; if (r !== 1'b1) begin n_bad++; $display("[TB] FAIL ebreak_retire: got %0b want 1", r); end
    n_cmp++; if ({halt, halt_code, imem_req} !== 4'b1000) begin n_bad++; $display("[TB] FAIL ebreak_halt: got halt=%0b code=%0d req=%0b want 1/0/0", halt, halt_code, imem_req); end
    imem_inst = 32'h0050_0513;
    imem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({retire, halt, imem_req, pc, a0} !== {1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'd1}) begin
        n_bad++;
        $display("[TB] FAIL halt_sticky[%0d]: got ret=%0b halt=%0b req=%0b pc=%h a0=%h", i, retire, halt, imem_req, pc, a0);
      end
    end
    imem_valid = 1'b0;
  endtask

  task automatic test_rv32e();
    rst_e = 1'b0;
    valid_e = 1'b0;
    inst_e = 32'h0010_0513;
    repeat (2) @(negedge clk);
    rst_e = 1'b1;
    valid_e = 1'b1;
    @(negedge clk);
    valid_e = 1'b0;
    @(negedge clk);
    n_cmp++; if ({halt_e, a0_e} !== {1'b0, 32'd1}) begin n_bad++; $display("[TB] FAIL rv32e_legal: got halt=%0b a0=%h want 0/1", halt_e, a0_e); end
    inst_e = 32'h0010_0A13;
    valid_e = 1'b1;
    @(negedge clk);
    valid_e = 1'b0;
    n_cmp++; if (retire_e !== 1'b0) begin n_bad++; $display("[TB] FAIL rv32e_retire: got %0b want 0", retire_e); end
    @(negedge clk);
    n_cmp++; if ({halt_e, code_e, pc_e} !== {1'b1, 2'd1, 32'h8000_0004}) begin n_bad++; $display("[TB] FAIL rv32e_illegal: got halt=%0b code=%0d pc=%h want 1/1/80000004", halt_e, code_e, pc_e); end
  endtask

  task automatic test_reset_exec();
    logic r;
    do_reset();
    imem_inst = 32'h0050_0513;
    imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    n_cmp++; if (retire !== 1'b1) begin n_bad++; $display("[TB] FAIL rexec_in_exec: got %0b want 1", retire); end
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("[TB] FAIL rexec_req_drop: got %0b want 0", imem_req); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if ({pc, a0} !== {RST_PC, 32'd0}) begin n_bad++; $display("[TB] FAIL rexec_discard: got pc=%h a0=%h want %h/0", pc, a0, RST_PC); end
    @(negedge clk);
    issue(32'h0010_0513, r);
    n_cmp++; if ({pc, a0} !== {32'h8000_0004, 32'd1}) begin n_bad++; $display("[TB] FAIL rexec_resume: got pc=%h a0=%h want 80000004/1", pc, a0); end
  endtask

  initial begin
    rst = 1'b0;
    rst_e = 1'b0;
    imem_valid = 1'b0;
    valid_e = 1'b0;
    imem_inst = '0;
    inst_e = '0;
    test_reset();
    test_addi();
    test_sequence();
    test_wait();
    test_jal();
    test_alu();
    test_ebreak();
    test_rv32e();
    test_reset_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
